// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder that streams one nibble per clock through a single 4-bit ripple adder.
// Optional signed-overflow output is enabled by defining NSA_OVERFLOW_EN.

module fourbit_adder_method1 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout,
    output logic       c3
);
    logic [4:0] c;

    always_comb begin
        sum  = '0;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < 4; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = c[4];
    // Carry into bit 3 is exposed so the top level can derive signed overflow.
    assign c3   = c[3];
endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef NSA_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);
    localparam int N    = WIDTH / 4;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             cout_q, cout_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [3:0]       nib_a;
    logic [3:0]       nib_b;
    logic [3:0]       nib_sum;
    logic             nib_cout;
`ifdef NSA_OVERFLOW_EN
    logic             nib_c3;
    logic             ovf_q, ovf_d;
`else
    logic             unused_nib_c3;
`endif

    assign nib_a = a_q[{idx_q, 2'b00} +: 4];
    assign nib_b = b_q[{idx_q, 2'b00} +: 4];

    fourbit_adder_method1 u_adder (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_q),
        .sum  (nib_sum),
        .cout (nib_cout),
`ifdef NSA_OVERFLOW_EN
        .c3   (nib_c3)
`else
        .c3   (unused_nib_c3)
`endif
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        cout_d  = cout_q;
`ifdef NSA_OVERFLOW_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[{idx_q, 2'b00} +: 4] = nib_sum;
                carry_d = nib_cout;
                if (idx_q == LAST_IDX) begin
                    cout_d  = nib_cout;
`ifdef NSA_OVERFLOW_EN
                    ovf_d   = nib_c3 ^ nib_cout;
`endif
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Handshake outputs are registered copies of the next-state decode.
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef NSA_OVERFLOW_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            cout_q      <= cout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef NSA_OVERFLOW_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef NSA_OVERFLOW_EN
    assign ovf       = ovf_q;
`endif
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed, scoreboard-based bench for nibble_serial_adder at WIDTH=16.
// Overflow checks are compiled in only when NSA_OVERFLOW_EN is defined.

module tb_nibble_serial_adder;
    localparam int WIDTH = 16;
    localparam int N     = WIDTH / 4;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef NSA_OVERFLOW_EN
    logic             ovf;
`endif

    exp_t sb[$];
    int   n_compared;
    int   n_mismatched;

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef NSA_OVERFLOW_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic ci);
        logic [WIDTH:0] t;
        exp_t           e;
        t      = {1'b0, x} + {1'b0, y} + (WIDTH + 1)'(ci);
        e.sum  = t[WIDTH-1:0];
        e.cout = t[WIDTH];
        e.ovf  = (x[WIDTH-1] == y[WIDTH-1]) && (t[WIDTH-1] != x[WIDTH-1]);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_compared++;
        assert (observed === expected)
        else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkResult(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checkOutput({tag, "_sb_nonempty"}, 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        checkOutput({tag, "_sum"}, 32'(sum), 32'(e.sum));
        checkOutput({tag, "_cout"}, 32'(cout), 32'(e.cout));
`ifdef NSA_OVERFLOW_EN
        checkOutput({tag, "_ovf"}, 32'(ovf), 32'(e.ovf));
`endif
    endtask

    // Waits for in_ready, presents one operand set for exactly one accept edge.
    task automatic applyStimulus(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic ci, input bit track);
        int cyc = 0;
        while (!in_ready && cyc < 20) begin
            tick();
            cyc++;
        end
        checkOutput("in_ready_before_accept", 32'(in_ready), 32'd1);
        a        = x;
        b        = y;
        cin      = ci;
        in_valid = 1'b1;
        if (track) sb.push_back(model(x, y, ci));
        tick();
        in_valid = 1'b0;
    endtask

    task automatic waitResult(input string tag);
        int cyc = 0;
        while (!out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        checkOutput({tag, "_latency"}, 32'(cyc), 32'(N));
        checkResult(tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] op_a [5];
        logic [WIDTH-1:0] op_b [5];
        logic             op_c [5];
        exp_t             held;
        int               idx;
        int               got;
        int               last_acc;
        bit               acc;

        n_compared   = 0;
        n_mismatched = 0;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        a            = '0;
        b            = '0;
        cin          = 1'b0;

        tick();
        tick();
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_sum", 32'(sum), 32'd0);
        checkOutput("reset_cout", 32'(cout), 32'd0);
`ifdef NSA_OVERFLOW_EN
        checkOutput("reset_ovf", 32'(ovf), 32'd0);
`endif
        rst_n = 1'b1;
        tick();

        applyStimulus(16'h1234, 16'h4321, 1'b0, 1'b1);
        checkOutput("run_in_ready", 32'(in_ready), 32'd0);
        waitResult("basic");
        checkOutput("idle_after_done", 32'(in_ready), 32'd1);

        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b1);
        waitResult("wrap");
        applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b1);
        waitResult("pos_ovf");
        applyStimulus(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
        waitResult("all_ones_cin");
        applyStimulus(16'h0FFF, 16'h0001, 1'b0, 1'b1);
        waitResult("carry_chain");
        applyStimulus(16'h8000, 16'h8000, 1'b1, 1'b1);
        waitResult("neg_ovf");

        // Backpressure: result must hold while inputs churn.
        applyStimulus(16'hBEEF, 16'h1357, 1'b1, 1'b1);
        idx = 0;
        while (!out_valid && idx < 20) begin
            tick();
            idx++;
        end
        held = sb[0];
        for (int i = 0; i < 10; i++) begin
            a        = WIDTH'($urandom);
            b        = WIDTH'($urandom);
            cin      = 1'($urandom);
            in_valid = 1'($urandom);
            tick();
            checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
            checkOutput("bp_sum", 32'(sum), 32'(held.sum));
            checkOutput("bp_cout", 32'(cout), 32'(held.cout));
        end
        in_valid = 1'b0;
        checkResult("bp");
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("bp_release_in_ready", 32'(in_ready), 32'd1);
        checkOutput("bp_release_out_valid", 32'(out_valid), 32'd0);

        // Reset lands on the edge that would compute nibble 2.
        applyStimulus(16'h5678, 16'h1111, 1'b0, 1'b0);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("midrun_rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("midrun_rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrun_rst_sum", 32'(sum), 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput("midrun_no_out_valid", 32'(out_valid), 32'd0);
        end
        applyStimulus(16'h0001, 16'h0001, 1'b0, 1'b1);
        waitResult("after_reset");

        // Back-to-back: in_valid held high, accepts must be N+2 cycles apart.
        op_a[0] = 16'hAAAA; op_b[0] = 16'h5555; op_c[0] = 1'b1;
        op_a[1] = 16'h8000; op_b[1] = 16'h8000; op_c[1] = 1'b0;
        op_a[2] = 16'h1111; op_b[2] = 16'h2222; op_c[2] = 1'b1;
        op_a[3] = 16'hFFF0; op_b[3] = 16'h0010; op_c[3] = 1'b0;
        op_a[4] = 16'h7FFF; op_b[4] = 16'h7FFF; op_c[4] = 1'b1;
        idx       = 0;
        got       = 0;
        last_acc  = -1;
        out_ready = 1'b1;
        a         = op_a[0];
        b         = op_b[0];
        cin       = op_c[0];
        in_valid  = 1'b1;
        sb.push_back(model(op_a[0], op_b[0], op_c[0]));
        for (int c = 0; c < 200 && got < 5; c++) begin
            acc = in_ready && in_valid;
            tick();
            if (acc) begin
                if (last_acc >= 0) checkOutput("b2b_spacing", 32'(c - last_acc), 32'(N + 2));
                last_acc = c;
                idx++;
                if (idx < 5) begin
                    a   = op_a[idx];
                    b   = op_b[idx];
                    cin = op_c[idx];
                    sb.push_back(model(op_a[idx], op_b[idx], op_c[idx]));
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid) begin
                checkResult("b2b");
                got++;
            end
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checkOutput("b2b_count", 32'(got), 32'd5);
        checkOutput("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle adder for WIDTH-bit operands built on one `fourbit_adder_method1` instance, which it feeds one nibble per clock while carrying between nibbles in a register. It sits directly upstream of the 4-bit adder stage and wraps it with a valid/ready input, a sequencing FSM and a held result register. This gives wide additions at 4-bit adder area.

## Interface
Parameters:
- `WIDTH`, default 16: operand width in bits. Must be a multiple of 4 and ≥ 4. N = WIDTH/4 nibbles.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  operands/cin valid.
- `in_ready`  out  1  block can accept operands.
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B.
- `cin`  in  1  carry-in to nibble 0.
- `out_valid`  out  1  result valid, held until accepted.
- `out_ready`  in  1  consumer accepts result.
- `sum`  out  WIDTH  result, unsigned A+B+cin modulo 2^WIDTH.
- `cout`  out  1  carry out of the MSB.
- `ovf`  out  1  signed overflow; present only with NSA_OVERFLOW_EN.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: latch `a`, `b` into operand registers; load carry register with `cin`; set nibble index=0; go to RUN.
- RUN: each cycle:
  - Present A[4i+3:4i], B[4i+3:4i] and the carry register to the 4-bit adder.
  - Write its 4-bit sum into sum register bits [4i+3:4i]; load its carryout into the carry register; increment i.
  - After the nibble with i=N-1: go to DONE, with `cout` = final carry.
- DONE:
  - `out_valid`=1; `sum`/`cout`/`ovf` stable.
  - On `out_ready`: go to IDLE.
  - `in_ready`=0 in DONE. There is no overlap of accept and result handshakes.
- Input operands are not sampled after the accept edge; changes on `a`/`b`/`cin` during RUN/DONE have no effect.
- `in_valid` ignored outside IDLE. `out_ready` ignored outside DONE.
- Nibble index counter width is clog2(N), minimum 1 bit. It never wraps past N-1; it is reset to 0 on every accept.
- Sum register bits are overwritten nibble by nibble. Their stale content is not visible, because `out_valid`=0 until DONE.

## Timing
- Reset: while `rst_n`=0 at a rising edge:
  - State becomes IDLE.
  - `sum`=0, `cout`=0, `ovf`=0, `out_valid`=0, carry and index registers = 0.
  - `in_ready` is 1 from the first cycle with state IDLE.
- Reset mid-RUN or in DONE: in-flight result discarded; no `out_valid` pulse follows.
- Latency:
  - Accept at edge t.
  - Nibble k is computed on edge t+1+k.
  - `out_valid` rises after edge t+N (N=4 for WIDTH=16).
- Throughput:
  - One addition per N+2 cycles minimum: accept cycle, N RUN cycles, one DONE cycle with `out_ready`=1.
  - Next accept is possible in the cycle after the DONE handshake.
- `in_ready`, `out_valid` are decoded from registered state only, with no combinational path from `in_valid`/`out_ready`.
- WIDTH=4: a single RUN cycle; latency 1.

## Configuration
- Macro `NSA_OVERFLOW_EN`.
- With the macro defined:
  - `ovf` port exists.
  - On the last RUN cycle, the block registers `ovf` = (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1). This needs an extra register of the MSB-stage carry-in, taken from the adder's bit-2 ripple carry on the final nibble.
  - `ovf` is held in DONE and cleared on reset.
- Without the macro: no `ovf` port and no associated logic; all other behaviour is identical.

## Test plan
- WIDTH=16, a=0x1234, b=0x4321, cin=0, `out_ready`=1 → `out_valid` 4 cycles after accept, `sum`=0x5555, `cout`=0.
- a=0xFFFF, b=0x0001, cin=0 → `sum`=0x0000, `cout`=1, `ovf`=0; a=0x7FFF, b=0x0001 → `sum`=0x8000, `cout`=0, `ovf`=1 (with NSA_OVERFLOW_EN).
- a=0xFFFF, b=0xFFFF, cin=1 → `sum`=0xFFFF, `cout`=1. Also check carry propagates across all nibble boundaries with a=0x0FFF, b=0x0001 → 0x1000.
- Backpressure: hold `out_ready`=0 for 10 cycles in DONE while toggling `a`/`b`/`in_valid` → `sum`/`cout` stable, `in_ready`=0, no new accept. Release → IDLE next cycle.
- Assert `rst_n`=0 for one edge during RUN nibble 2 → next cycle IDLE, `in_ready`=1, `out_valid`=0, `sum`=0. A subsequent 0x0001+0x0001 yields 0x0002.
- Back-to-back: `in_valid` held high with a new operand pair each accept, `out_ready`=1 → accepts spaced exactly N+2 cycles, each result correct and in order.
